// File: rtl/led_step_ctrl.sv
// led_step_ctrl
//   Button front-end and step generator for the LED pattern blocks.
//   Both raw buttons are synchronised (2 flops), debounced and edge
//   detected. A press on btn_ss toggles RUN, a press on btn_mode toggles
//   MODE. While RUN is set, a prescaler emits a one-cycle SS pulse every
//   DIV clocks; while paused it holds its phase.
//
// Parameters
//   DIV        step period in clocks (>= 2)
//   DB_CYCLES  stable cycles needed to accept a button level change (>= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   btn_ss    in   raw run/pause button (async, active-high)
//   btn_mode  in   raw direction button (async, active-high)
//   SS        out  registered step pulse, one cycle wide
//   MODE      out  registered direction flag
//   RUN       out  registered run flag
//
// Build option
//   LED_STEP_AUTOSTART_EN  when defined, RUN resets to 1 instead of 0.
module led_step_ctrl #(
  parameter int unsigned DIV       = 25_000_000,
  parameter int unsigned DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_ss,
  input  logic btn_mode,
  output logic SS,
  output logic MODE,
  output logic RUN
);

  localparam int unsigned PCW = $clog2(DIV);
  localparam int unsigned DBW = $clog2(DB_CYCLES);
  localparam logic [PCW-1:0] PC_MAX = PCW'(DIV - 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

`ifdef LED_STEP_AUTOSTART_EN
  localparam logic RUN_RST = 1'b1;
`else
  localparam logic RUN_RST = 1'b0;
`endif

  // Bit 0 = btn_ss, bit 1 = btn_mode throughout.
  logic [1:0]     w_btn;
  logic [1:0]     w_press;
  logic [1:0]     r_s0;
  logic [1:0]     r_s1;
  logic [1:0]     r_db;
  logic [1:0]     r_db_q;
  logic [DBW-1:0] r_dbc [2];
  logic [PCW-1:0] r_pc;
  logic           r_ss;
  logic           r_mode;
  logic           r_run;

  assign w_btn   = {btn_mode, btn_ss};
  assign w_press = r_db & ~r_db_q;

  // Synchroniser, debouncer and edge-detect delay for both buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s0   <= '0;
      r_s1   <= '0;
      r_db   <= '0;
      r_db_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_dbc[i] <= '0;
      end
    end else begin
      r_s0   <= w_btn;
      r_s1   <= r_s0;
      r_db_q <= r_db;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_s1[i] != r_db[i]) begin
          // DB_CYCLES-th consecutive mismatch accepts the new level.
          if (r_dbc[i] == DB_MAX) begin
            r_db[i]  <= r_s1[i];
            r_dbc[i] <= '0;
          end else begin
            r_dbc[i] <= r_dbc[i] + DBW'(1);
          end
        end else begin
          r_dbc[i] <= '0;
        end
      end
    end
  end

  // Flags and prescaler. The prescaler looks at the pre-edge RUN, so a
  // stop landing on a wrap edge still emits that last pulse, and a start
  // on a wrap-eligible edge does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run  <= RUN_RST;
      r_mode <= 1'b0;
      r_pc   <= '0;
      r_ss   <= 1'b0;
    end else begin
      r_run  <= r_run ^ w_press[0];
      r_mode <= r_mode ^ w_press[1];
      if (r_run) begin
        if (r_pc == PC_MAX) begin
          r_pc <= '0;
          r_ss <= 1'b1;
        end else begin
          r_pc <= r_pc + PCW'(1);
          r_ss <= 1'b0;
        end
      end else begin
        r_ss <= 1'b0;
      end
    end
  end

  assign SS   = r_ss;
  assign MODE = r_mode;
  assign RUN  = r_run;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Self-checking bench for led_step_ctrl with DIV=4, DB_CYCLES=3.
// A cycle-level reference model derives the debounced levels from the
// recent history of synchronised samples and the step pulses from a count
// of running edges.
module tb_led_step_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned DB  = 3;
`ifdef LED_STEP_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_ss = 1'b0;
  logic btn_mode = 1'b0;
  logic SS, MODE, RUN;

  int tot = 0;
  int bad = 0;

  led_step_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_mode(btn_mode),
    .SS(SS), .MODE(MODE), .RUN(RUN)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit hr_ss[$];
  bit hr_md[$];
  bit hs_ss[$];
  bit hs_md[$];
  bit m_db_ss, m_db_md, m_dbq_ss, m_dbq_md;
  bit m_run, m_mode, m_ss;
  int m_steps;
  bit t_s1_ss, t_s1_md, t_p_ss, t_p_md, t_run_pre;

  // True when the last DB synchronised samples all disagree with db.
  function automatic bit flip_due(input bit h[$], input bit db);
    if (h.size() < DB) return 1'b0;
    for (int i = h.size() - DB; i < h.size(); i++)
      if (h[i] == db) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_pc();
    return m_steps % DIV;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hr_ss.delete(); hr_md.delete(); hs_ss.delete(); hs_md.delete();
      m_db_ss = 0; m_db_md = 0; m_dbq_ss = 0; m_dbq_md = 0;
      m_run = AUTO; m_mode = 0; m_ss = 0; m_steps = 0;
    end else begin
      // Synchroniser output before this edge = raw value two edges ago.
      t_s1_ss = (hr_ss.size() >= 2) ? hr_ss[hr_ss.size()-2] : 1'b0;
      t_s1_md = (hr_md.size() >= 2) ? hr_md[hr_md.size()-2] : 1'b0;
      hr_ss.push_back(btn_ss);   if (hr_ss.size() > 2) void'(hr_ss.pop_front());
      hr_md.push_back(btn_mode); if (hr_md.size() > 2) void'(hr_md.pop_front());
      hs_ss.push_back(t_s1_ss);  if (hs_ss.size() > DB) void'(hs_ss.pop_front());
      hs_md.push_back(t_s1_md);  if (hs_md.size() > DB) void'(hs_md.pop_front());
      t_p_ss = m_db_ss & ~m_dbq_ss;
      t_p_md = m_db_md & ~m_dbq_md;
      m_dbq_ss = m_db_ss;
      m_dbq_md = m_db_md;
      if (flip_due(hs_ss, m_db_ss)) m_db_ss = ~m_db_ss;
      if (flip_due(hs_md, m_db_md)) m_db_md = ~m_db_md;
      t_run_pre = m_run;
      m_run  = m_run ^ t_p_ss;
      m_mode = m_mode ^ t_p_md;
      if (t_run_pre) begin
        m_ss = ((m_steps % DIV) == DIV - 1);
        m_steps++;
      end else begin
        m_ss = 1'b0;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    tot++;
    if ({SS, MODE, RUN} !== {1'b0, 1'b0, AUTO}) begin
      bad++; $display("FAIL reset_async got=%b exp=%b", {SS, MODE, RUN}, {1'b0, 1'b0, AUTO});
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tot++;
      if ({SS, MODE, RUN} !== {(AUTO && (k % DIV == 0)), 1'b0, AUTO} ||
          {SS, MODE, RUN} !== {m_ss, m_mode, m_run}) begin
        bad++; $display("FAIL reset_idle k=%0d got=%b exp=%b", k, {SS, MODE, RUN},
                        {(AUTO && (k % DIV == 0)), 1'b0, AUTO});
      end
    end
  endtask

  task automatic test_clean_press();
    btn_ss = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      @(negedge clk);
      tot++;
      if (RUN !== (e >= 5) || SS !== (e == 9 || e == 13 || e == 17)) begin
        bad++; $display("FAIL clean_press e=%0d got SS=%b RUN=%b exp SS=%b RUN=%b", e, SS, RUN,
                        (e == 9 || e == 13 || e == 17), (e >= 5));
      end
    end
    // release, pause, stay paused, release, resume: model tracks phase.
    for (int ph = 0; ph < 5; ph++) begin
      btn_ss = (ph == 1 || ph == 3);
      for (int c = 0; c < 11; c++) begin
        @(negedge clk);
        tot++;
        if ({SS, MODE, RUN} !== {m_ss, m_mode, m_run}) begin
          bad++; $display("FAIL pause_resume ph=%0d c=%0d got=%b exp=%b", ph, c,
                          {SS, MODE, RUN}, {m_ss, m_mode, m_run});
        end
      end
      if (ph == 2) begin
        tot++;
        if (RUN !== 1'b0) begin
          bad++; $display("FAIL paused_run got=%b exp=0", RUN);
        end
      end
    end
  endtask

  task automatic test_stop_on_wrap();
    int guard = 0;
    while (!(m_run && m_pc() == 2) && guard < 16) begin
      @(negedge clk); guard++;
    end
    tot++;
    if (guard >= 16) begin
      bad++; $display("FAIL stop_wrap_setup got guard=%0d exp <16", guard);
    end
    btn_ss = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(negedge clk);
      tot++;
      if (SS !== (e == 1 || e == 5) || RUN !== (e < 5)) begin
        bad++; $display("FAIL stop_on_wrap e=%0d got SS=%b RUN=%b exp SS=%b RUN=%b", e, SS, RUN,
                        (e == 1 || e == 5), (e < 5));
      end
    end
    btn_ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_bounce();
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin btn_mode = pat[i]; @(negedge clk); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tot++;
      if (MODE !== 1'b0) begin
        bad++; $display("FAIL bounce_reject c=%0d got=%b exp=0", c, MODE);
      end
    end
    for (int i = 0; i < 4; i++) begin btn_mode = pat[i]; @(negedge clk); end
    btn_mode = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      @(negedge clk);
      tot++;
      if (MODE !== (e >= 5)) begin
        bad++; $display("FAIL bounce_settle e=%0d got=%b exp=%b", e, MODE, (e >= 5));
      end
    end
    btn_mode = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int guard = 0;
    btn_ss = 1'b1;
    repeat (8) @(negedge clk);
    btn_ss = 1'b0;
    while (!(m_run && m_pc() == 2) && guard < 16) begin
      @(negedge clk); guard++;
    end
    tot++;
    if ({RUN, MODE} !== 2'b11 || guard >= 16) begin
      bad++; $display("FAIL midrun_setup got RUN,MODE=%b guard=%0d exp 11 <16", {RUN, MODE}, guard);
    end
    #2 reset = 1'b1;
    #1;
    tot++;
    if ({SS, MODE, RUN} !== {1'b0, 1'b0, AUTO}) begin
      bad++; $display("FAIL midrun_async got=%b exp=%b", {SS, MODE, RUN}, {1'b0, 1'b0, AUTO});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    btn_ss = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      @(negedge clk);
      tot++;
      if (RUN !== ((e >= 5) ^ AUTO)) begin
        bad++; $display("FAIL midrun_latency e=%0d got=%b exp=%b", e, RUN, ((e >= 5) ^ AUTO));
      end
    end
    btn_ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) btn_ss = ~btn_ss;
      if ($urandom_range(0, 6) == 0) btn_mode = ~btn_mode;
      @(negedge clk);
      tot++;
      if ({SS, MODE, RUN} !== {m_ss, m_mode, m_run}) begin
        bad++; $display("FAIL random c=%0d got=%b exp=%b", c, {SS, MODE, RUN},
                        {m_ss, m_mode, m_run});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_stop_on_wrap();
    test_bounce();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/led_step_ctrl.md
# led_step_ctrl

Control stage that drives the LED pattern blocks (shift, fill, inner/outer variants) from two raw push-buttons and the board clock. It synchronises and debounces both buttons and toggles a run/pause flag and a direction flag. A prescaler emits a one-cycle `SS` step pulse every `DIV` clocks while running, so the downstream pattern register advances at a visible rate. `SS` and `MODE` connect directly to the same-named inputs of the pattern block.

## Interface
- `DIV`, default 25_000_000: step period in clock cycles. Legal range ≥ 2.
- `DB_CYCLES`, default 500_000: consecutive stable cycles required to accept a button level change. Legal range ≥ 2.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset. Clears all state immediately.
- `btn_ss`  in  1  raw run/pause button, asynchronous, active-high.
- `btn_mode`  in  1  raw direction button, asynchronous, active-high.
- `SS`  out  1  step pulse, registered. High for exactly one cycle per step.
- `MODE`  out  1  direction, registered. 0 = right-to-left / outer-to-inner; 1 = left-to-right / inner-to-outer.
- `RUN`  out  1  run flag, registered. 1 = stepping, 0 = paused.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser (`s0`→`s1`). Both flops reset to 0.
- **Debouncer (one per button):**
  - Holds a debounced level `db` (reset 0) and a counter `dbc` of width clog2(`DB_CYCLES`) (reset 0).
  - When `s1` ≠ `db`: `dbc` increments. When `dbc` = `DB_CYCLES`-1 and the mismatch persists, `db` takes `s1` and `dbc` clears on the same edge.
  - When `s1` = `db`: `dbc` clears.
  - Result: `db` changes after exactly `DB_CYCLES` consecutive mismatching cycles. Any bounce shorter than that is discarded.
- **Edge detect:** `db_q` is `db` delayed one cycle. A press event is `db & ~db_q`. Releases generate no event.
- **Run flag:** a press event on `btn_ss` toggles `RUN`.
- **Direction flag:** a press event on `btn_mode` toggles `MODE`. This works whether `RUN` is 0 or 1.
- **Prescaler:**
  - Counter `pc` of width clog2(`DIV`), reset 0.
  - While `RUN`=1: `pc` increments. At `DIV`-1 it wraps to 0 and `SS` is set to 1 on that same edge. On every other edge `SS` is 0.
  - While `RUN`=0: `pc` holds its value and `SS` is 0. Resuming continues from the held phase; there is no restart.
- **Reset values:** `SS`=0, `MODE`=0, `RUN`=0 (see Configuration), `pc`=0, and all synchroniser, debounce and edge flops 0.

## Timing
- **Button-to-flag latency:** the input goes high before edge E0 and stays stable. `s1` is high after E1. `db` is high after E1+`DB_CYCLES`. `RUN`/`MODE` toggles at E1+`DB_CYCLES`+1. Total: `DB_CYCLES`+2 edges.
- **Step period:** when `RUN` rises at edge R with `pc`=0, the first `SS` high is registered at edge R+`DIV`. Later pulses follow every `DIV` cycles. The pulse width is always 1 cycle.
- **Simultaneous events:**
  - Prescaler logic uses the pre-edge `RUN` value. If `RUN` clears on the same edge where `pc` wraps, that final `SS` pulse is still issued.
  - If `RUN` sets on a wrap-eligible edge, no pulse is issued.
- **Both buttons pressed:** both flags toggle independently, on the same edge if their debouncers complete together.
- **Reset mid-operation:** every output drops to its reset value asynchronously, with no wait for a clock. The first toggle after reset release needs a full debounce again.
- **Held button:** a held button produces one event only. The release then needs `DB_CYCLES` stable cycles before the next press is accepted.

## Configuration
- `LED_STEP_AUTOSTART_EN` defined: `RUN` resets to 1. Stepping starts on the first clock after reset release, with the first `SS` at edge `DIV` after release. The `btn_ss` press still toggles `RUN`.
- Not defined: `RUN` resets to 0. Stepping begins only after a `btn_ss` press.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `DIV`=4 and `DB_CYCLES`=3.

- **Reset, macro undefined:** assert `reset` mid-cycle → `SS`=0, `MODE`=0, `RUN`=0 immediately. Hold 20 cycles with no buttons → `SS` never asserts.
- **Clean press:** `btn_ss` held high from edge 0 → `RUN`=1 at edge 5 (`DB_CYCLES`+2). `SS` pulses at edges 9, 13, 17, each one cycle wide. Release and press again → `RUN`=0 and `pc` frozen. The next press resumes with the original phase.
- **Bounce rejection:** `btn_mode` toggles 1,0,1,0 on alternate cycles, then stays 0 → `MODE` stays 0. The same burst followed by a steady 1 → `MODE`=1 exactly `DB_CYCLES`+2 edges after the last 0→1 transition.
- **Stop on wrap:** arrange for the `RUN` toggle-to-0 edge to coincide with `pc`=3 → `SS` is high for that one cycle, then stays 0.
- **Reset mid-run:** with `RUN`=1, `MODE`=1 and `pc`=2, pulse `reset` → all outputs 0 asynchronously. After release, a new press still needs the full 5-edge latency.
- **Macro defined:** build with `LED_STEP_AUTOSTART_EN` → `RUN`=1 during reset. First `SS` at edge 4 after release, then every 4 edges.
